// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state encoding, register addresses and reset colors for sprite_ctrl.
package sprite_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_UPDATE_X, ST_UPDATE_Y, ST_COMMIT} state_t;
   localparam logic [2:0] ADDR_POS_X = 3'd0;
   localparam logic [2:0] ADDR_POS_Y = 3'd1;
   localparam logic [2:0] ADDR_VEL   = 3'd2;
   localparam logic [2:0] ADDR_OBJ   = 3'd3;
   localparam logic [2:0] ADDR_BKG   = 3'd4;
   localparam logic [2:0] ADDR_CTRL  = 3'd5;
   localparam logic [23:0] OBJ_COLOR_RST = 24'hFFFFFF;
   localparam logic [23:0] BKG_COLOR_RST = 24'h000000;
   function automatic logic [31:0] clamp_pos(input logic [31:0] p, input logic [31:0] max);
      return (p > max) ? max : p;
   endfunction
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: one-axis motion step, bouncing off 0 and MAX by reversing velocity.
module sprite_axis_step (
   input  logic        [31:0] i_p,
   input  logic signed [7:0]  i_d,
   input  logic        [31:0] i_max,
   output logic        [31:0] o_p,
   output logic signed [7:0]  o_d
);
   logic signed [32:0] w_n;
   logic signed [7:0]  w_neg_d;
   logic               w_under;
   logic               w_over;
   assign w_n     = $signed({1'b0, i_p}) + 33'(i_d);
   // -128 has no positive counterpart in 8 bits, so it bounces back as +127
   assign w_neg_d = (i_d == 8'sh80) ? 8'sh7F : -i_d;
   assign w_under = w_n[32];
   assign w_over  = !w_under && (w_n[31:0] > i_max);
   assign o_p     = w_under ? '0 : w_over ? i_max : w_n[31:0];
   assign o_d     = (w_under || w_over) ? w_neg_d : i_d;
endmodule

// File: rtl/sprite_ctrl.sv
// sprite_ctrl: host-programmable bouncing sprite; shadow registers are applied once per frame
// so the visible position and colors never change mid-frame.
module sprite_ctrl
   import sprite_pkg::*;
#(
   parameter int PIXELS_X = 800,
   parameter int PIXELS_Y = 600,
   parameter int SPRITE_W = 46,
   parameter int SPRITE_H = 46,
   parameter int INIT_X   = 400,
   parameter int INIT_Y   = 400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] row,
   input  logic [31:0] col,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   output logic [31:0] sprite_x,
   output logic [31:0] sprite_y,
   output logic [23:0] obj_color,
   output logic [23:0] bkg_color,
   output logic        frame_tick
);
   localparam logic [31:0] X_MAX = 32'(PIXELS_X - SPRITE_W);
   localparam logic [31:0] Y_MAX = 32'(PIXELS_Y - SPRITE_H);
   state_t             r_state, w_next;
   logic               w_frame_start;
   logic               w_wr;
   logic        [31:0] r_pos_x, r_pos_y;
   logic               r_pend_x, r_pend_y;
   logic signed [7:0]  r_dx, r_dy;
   logic        [23:0] r_obj_sh, r_bkg_sh;
   logic               r_en;
   logic        [31:0] r_wx, r_wy;
   logic        [31:0] r_sprite_x, r_sprite_y;
   logic        [23:0] r_obj, r_bkg;
   logic        [31:0] w_px, w_py;
   logic signed [7:0]  w_dx, w_dy;

   sprite_axis_step u_step_x (.i_p(r_sprite_x), .i_d(r_dx), .i_max(X_MAX), .o_p(w_px), .o_d(w_dx));
   sprite_axis_step u_step_y (.i_p(r_sprite_y), .i_d(r_dy), .i_max(Y_MAX), .o_p(w_py), .o_d(w_dy));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= ST_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next        = r_state;
      cmd_ready     = 1'b0;
      frame_tick    = 1'b0;
      w_frame_start = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            cmd_ready     = 1'b1;
            w_frame_start = (row == 32'(PIXELS_Y)) && (col == '0);
            w_next        = w_frame_start ? ST_UPDATE_X : ST_IDLE;
         end
         ST_UPDATE_X: begin
            frame_tick = 1'b1;
            w_next     = ST_UPDATE_Y;
         end
         ST_UPDATE_Y: w_next = ST_COMMIT;
         ST_COMMIT:   w_next = ST_IDLE;
      endcase
   end

   assign w_wr = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pos_x    <= '0;
         r_pos_y    <= '0;
         r_pend_x   <= 1'b0;
         r_pend_y   <= 1'b0;
         r_dx       <= '0;
         r_dy       <= '0;
         r_obj_sh   <= OBJ_COLOR_RST;
         r_bkg_sh   <= BKG_COLOR_RST;
         r_en       <= 1'b0;
         r_wx       <= 32'(INIT_X);
         r_wy       <= 32'(INIT_Y);
         r_sprite_x <= 32'(INIT_X);
         r_sprite_y <= 32'(INIT_Y);
         r_obj      <= OBJ_COLOR_RST;
         r_bkg      <= BKG_COLOR_RST;
      end else begin
         if (w_wr)
            case (cmd_addr)
               ADDR_POS_X: begin
                  r_pos_x  <= cmd_data;
                  r_pend_x <= 1'b1;
               end
               ADDR_POS_Y: begin
                  r_pos_y  <= cmd_data;
                  r_pend_y <= 1'b1;
               end
               ADDR_VEL: begin
                  r_dx <= cmd_data[7:0];
                  r_dy <= cmd_data[15:8];
               end
               ADDR_OBJ:  r_obj_sh <= cmd_data[23:0];
               ADDR_BKG:  r_bkg_sh <= cmd_data[23:0];
               ADDR_CTRL: r_en     <= cmd_data[0];
               default: ;
            endcase
         // a host-written position overrides motion for that axis this frame
         if (r_state == ST_UPDATE_X) begin
            r_wx <= r_pend_x ? clamp_pos(r_pos_x, X_MAX) : r_en ? w_px : r_sprite_x;
            if (!r_pend_x && r_en) r_dx <= w_dx;
         end
         if (r_state == ST_UPDATE_Y) begin
            r_wy <= r_pend_y ? clamp_pos(r_pos_y, Y_MAX) : r_en ? w_py : r_sprite_y;
            if (!r_pend_y && r_en) r_dy <= w_dy;
         end
         if (r_state == ST_COMMIT) begin
            r_sprite_x <= r_wx;
            r_sprite_y <= r_wy;
            r_obj      <= r_obj_sh;
            r_bkg      <= r_bkg_sh;
            r_pend_x   <= 1'b0;
            r_pend_y   <= 1'b0;
         end
      end

   assign sprite_x  = r_sprite_x;
   assign sprite_y  = r_sprite_y;
   assign obj_color = r_obj;
   assign bkg_color = r_bkg;
endmodule

// File: tb/tb_sprite_ctrl.sv
// tb_sprite_ctrl: scoreboard bench; a frame-level model predicts each commit, a monitor checks
// every cycle against the last predicted commit and pops a new one whenever cmd_ready returns.
module tb_sprite_ctrl;
   localparam int PY = 600, XMAX = 754, YMAX = 554;
   logic        clk = 0, rst_n = 0;
   logic [31:0] row = 0, col = 0;
   logic        cmd_valid = 0;
   logic [2:0]  cmd_addr = 0;
   logic [31:0] cmd_data = 0;
   logic        cmd_ready, frame_tick;
   logic [31:0] sprite_x, sprite_y;
   logic [23:0] obj_color, bkg_color;

   sprite_ctrl #(.PIXELS_X(800), .PIXELS_Y(600), .SPRITE_W(46), .SPRITE_H(46), .INIT_X(400), .INIT_Y(400)) dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .obj_color(obj_color), .bkg_color(bkg_color), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   typedef struct { int x; int y; logic [23:0] obj; logic [23:0] bkg; } exp_t;
   exp_t exp_q[$];
   exp_t cur;
   int n_checks = 0, n_fail = 0;
   int m_x, m_y, m_dx, m_dy;
   logic [31:0] m_wx, m_wy;
   bit m_px, m_py, m_en;
   logic [23:0] m_obj, m_bkg;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_x = 400; m_y = 400; m_dx = 0; m_dy = 0; m_en = 0;
      m_px = 0; m_py = 0; m_wx = 0; m_wy = 0;
      m_obj = 24'hFFFFFF; m_bkg = 24'h000000;
   endfunction

   function automatic void model_write(input int a, input logic [31:0] d);
      byte b0, b1;
      b0 = d[7:0];
      b1 = d[15:8];
      case (a)
         0: begin m_wx = d; m_px = 1; end
         1: begin m_wy = d; m_py = 1; end
         2: begin m_dx = b0; m_dy = b1; end
         3: m_obj = d[23:0];
         4: m_bkg = d[23:0];
         5: m_en = d[0];
         default: ;
      endcase
   endfunction

   function automatic int neg(input int d);
      return (d == -128) ? 127 : -d;
   endfunction

   function automatic void axis(inout int p, inout int d, input int mx);
      int n;
      n = p + d;
      if (n < 0) begin p = 0; d = neg(d); end
      else if (n > mx) begin p = mx; d = neg(d); end
      else p = n;
   endfunction

   function automatic void model_frame();
      if (m_px) m_x = (m_wx > XMAX) ? XMAX : int'(m_wx);
      else if (m_en) axis(m_x, m_dx, XMAX);
      if (m_py) m_y = (m_wy > YMAX) ? YMAX : int'(m_wy);
      else if (m_en) axis(m_y, m_dy, YMAX);
      m_px = 0; m_py = 0;
      exp_q.push_back('{m_x, m_y, m_obj, m_bkg});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20 && !cmd_ready; k++) tick();
      if (!cmd_ready) check("idle_timeout", 64'(cmd_ready), 64'd1);
   endtask

   task automatic write(input int a, input logic [31:0] d);
      wait_idle();
      cmd_valid = 1; cmd_addr = a[2:0]; cmd_data = d;
      tick();
      cmd_valid = 0;
      model_write(a, d);
   endtask

   task automatic frame();
      wait_idle();
      row = PY; col = 0;
      tick();
      row = 0;
      model_frame();
      repeat (4) tick();
   endtask

   // write issued in the same cycle as frame start must land in that frame
   task automatic frame_wr(input int a, input logic [31:0] d);
      wait_idle();
      row = PY; col = 0;
      cmd_valid = 1; cmd_addr = a[2:0]; cmd_data = d;
      tick();
      row = 0; cmd_valid = 0;
      model_write(a, d);
      model_frame();
      repeat (4) tick();
   endtask

   int low_cnt = 0;
   bit prev_ready = 1;
   always @(negedge clk) begin
      if (!rst_n) begin
         low_cnt = 0; prev_ready = 1;
         cur = '{400, 400, 24'hFFFFFF, 24'h000000};
      end else begin
         check("frame_tick", 64'(frame_tick), 64'(!cmd_ready && low_cnt == 0));
         if (cmd_ready && !prev_ready) begin
            check("busy_len", 64'(low_cnt), 64'd3);
            if (exp_q.size() == 0) check("unexpected_commit", 64'd1, 64'd0);
            else cur = exp_q.pop_front();
            low_cnt = 0;
         end else if (!cmd_ready) low_cnt++;
         prev_ready = cmd_ready;
         check("sprite_x", 64'(sprite_x), 64'(cur.x));
         check("sprite_y", 64'(sprite_y), 64'(cur.y));
         check("obj_color", 64'(obj_color), 64'(cur.obj));
         check("bkg_color", 64'(bkg_color), 64'(cur.bkg));
      end
   end

   initial begin
      int w, a;
      logic [31:0] d;
      model_reset();
      repeat (3) tick();
      check("rst_x", 64'(sprite_x), 64'd400);
      check("rst_y", 64'(sprite_y), 64'd400);
      check("rst_obj", 64'(obj_color), 64'hFFFFFF);
      check("rst_bkg", 64'(bkg_color), 64'h0);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_tick", 64'(frame_tick), 64'd0);
      rst_n = 1;
      tick();
      // right wall bounce: 750 -> 754 (dx flips) -> 749
      write(0, 750); write(2, 32'h0000_0005); write(5, 1);
      frame(); frame(); frame();
      // top wall bounce: 2 -> 0 (dy flips) -> 5
      write(1, 2); write(2, 32'h0000_FB00);
      frame(); frame(); frame();
      // write held from T+1 is accepted only when IDLE returns in T+4
      wait_idle();
      row = PY; col = 0;
      tick();
      row = 0;
      model_frame();
      cmd_valid = 1; cmd_addr = 3'd3; cmd_data = 32'h0000FF00;
      w = 0;
      while (!cmd_ready && w < 20) begin tick(); w++; end
      check("accept_cycle", 64'(w), 64'd3);
      tick();
      cmd_valid = 0;
      model_write(3, 32'h0000FF00);
      check("obj_not_yet", 64'(obj_color), 64'hFFFFFF);
      frame();
      // host position overrides motion for one frame
      write(2, 32'h0000_0003); write(5, 1);
      frame();
      write(0, 100);
      frame(); frame();
      frame_wr(4, 32'h00123456);
      frame_wr(0, 32'd5000);
      // randomized traffic
      repeat (40) begin
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            a = $urandom_range(0, 7);
            d = (a < 2) ? 32'($urandom_range(0, 1000)) : $urandom;
            if (a == 2 && $urandom_range(0, 3) == 0) d[7:0] = 8'h80;
            if (a == 2 && $urandom_range(0, 3) == 0) d[15:8] = 8'h80;
            write(a, d);
         end
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 4) == 0) frame_wr($urandom_range(0, 5), 32'($urandom_range(0, 900)));
         else frame();
      end
      // reset in the middle of an update aborts the frame without committing
      write(0, 123);
      wait_idle();
      row = PY; col = 0;
      tick();
      row = 0;
      tick();
      rst_n = 0;
      #1;
      check("abort_x", 64'(sprite_x), 64'd400);
      check("abort_y", 64'(sprite_y), 64'd400);
      check("abort_obj", 64'(obj_color), 64'hFFFFFF);
      check("abort_bkg", 64'(bkg_color), 64'h0);
      check("abort_ready", 64'(cmd_ready), 64'd1);
      check("abort_tick", 64'(frame_tick), 64'd0);
      model_reset();
      tick();
      rst_n = 1;
      repeat (4) begin
         tick();
         check("no_tick_after_abort", 64'(frame_tick), 64'd0);
      end
      frame();
      write(5, 1); write(2, 32'h0000_FE02);
      frame(); frame();
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sprite_ctrl.md
SPRITE_CTRL -- requirements
Module: sprite_ctrl

Interface
REQ-001 SHALL have parameter PIXELS_X, default 800, visible columns.
REQ-002 SHALL have parameter PIXELS_Y, default 600, visible rows.
REQ-003 SHALL have parameter SPRITE_W, default 46, sprite width in pixels.
REQ-004 SHALL have parameter SPRITE_H, default 46, sprite height in pixels.
REQ-005 SHALL have parameters INIT_X and INIT_Y, default 400 each, the sprite position after reset.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1 bit, the pixel clock.
REQ-008 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-009 SHALL have ports row and col, input, 32 bits each, giving the current scan position.
REQ-010 SHALL have ports cmd_valid (input, 1 bit), cmd_ready (output, 1 bit), cmd_addr (input, 3 bits) and cmd_data (input, 32 bits), forming the register-write handshake.
REQ-011 SHALL have ports sprite_x and sprite_y, output, 32 bits each, giving the committed sprite origin.
REQ-012 SHALL have ports obj_color and bkg_color, output, 24 bits each, RGB888.
REQ-013 SHALL have port frame_tick, output, 1 bit, a one-cycle pulse at each frame update.

Function
REQ-014 SHALL accept a write when cmd_valid and cmd_ready are both 1 on the same clk edge; cmd_ready SHALL be 1 exactly when the FSM is in IDLE.
REQ-015 SHALL decode cmd_addr into shadow registers as follows:
- 0: pos_x
- 1: pos_y
- 2: velocity, dx=cmd_data[7:0] and dy=cmd_data[15:8], both signed
- 3: obj_color=cmd_data[23:0]
- 4: bkg_color=cmd_data[23:0]
- 5: ctrl, bit0=motion enable
- 6 and 7: write accepted, no effect
REQ-016 SHALL have FSM states IDLE, UPDATE_X, UPDATE_Y and COMMIT, with transitions IDLE->UPDATE_X on frame start, UPDATE_X->UPDATE_Y, UPDATE_Y->COMMIT and COMMIT->IDLE unconditionally.
REQ-017 SHALL define frame start as the cycle T in which row==PIXELS_Y and col==0, sampled in IDLE only; frame_tick SHALL be 1 in cycle T+1 only.
REQ-018 SHALL hold cmd_ready at 0 in T+1..T+3 and return it to 1 in T+4; the committed outputs SHALL change at the T+4 edge and at no other time, so there is no mid-frame tearing.
REQ-019 SHALL handle a write accepted in cycle T by including it in that frame's commit.
REQ-020 SHALL compute each axis in UPDATE_X/UPDATE_Y, when enable=1, as n = p + d, using 33-bit signed arithmetic with d sign-extended:
- if n < 0: p=0 and d=-d
- else if n > MAX: p=MAX and d=-d
- else: p=n
REQ-021 SHALL take MAX as PIXELS_X-SPRITE_W (754) for X and PIXELS_Y-SPRITE_H (554) for Y.
REQ-022 SHALL commit a host-written position instead of the motion result when pos_x or pos_y was written since the last commit, with motion skipped for that axis that frame.
REQ-023 SHALL clamp any host-written position greater than MAX to MAX at commit.
REQ-024 SHALL, when d=-128 is negated, saturate it to +127.
REQ-025 SHALL leave the position unchanged when enable=0, while still pulsing frame_tick and committing colors.

Reset
REQ-026 SHALL, while rst_n=0, drive these values:
- state=IDLE
- sprite_x=INIT_X, sprite_y=INIT_Y
- obj_color=24'hFFFFFF, bkg_color=24'h000000
- dx=dy=0, enable=0
- frame_tick=0, cmd_ready=1
- all pending-write flags cleared
REQ-027 SHALL abort any update in progress when reset is asserted mid-update, with no partial commit.

Structure
REQ-028 SHALL place the cmd_addr constants, the state encoding and the reset color constants in the shared package sprite_pkg.
REQ-029 SHALL implement the axis computation as one sub-module, sprite_axis_step (inputs p, d, MAX; outputs next p and next d), instantiated once per axis.

Verification
REQ-030 SHALL cover: reset, then read outputs -> sprite_x=400, sprite_y=400, obj_color=FFFFFF, bkg_color=000000, cmd_ready=1.
REQ-031 SHALL cover: pos_x=750, dx=+5, enable=1, then one frame -> sprite_x=754 and dx=-5; the next frame -> sprite_x=749.
REQ-032 SHALL cover: pos_y=2, dy=-5, then one frame -> sprite_y=0 and dy=+5; the next frame -> sprite_y=5.
REQ-033 SHALL cover: cmd_valid held from T+1 with addr 3 and data 00FF00 -> accepted at T+4, with obj_color=00FF00 only after the next frame commit.
REQ-034 SHALL cover: dx=+3, enable=1, pos_x=100 written mid-frame -> committed sprite_x=100 (not 103), then 103 on the following frame.
REQ-035 SHALL cover: rst_n pulsed low in T+2 -> all outputs at reset values, no frame_tick at T+1 of the aborted frame after release, and normal operation on the next frame start.
